// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port between the MEM pipeline stage (master)
// and the data memory (slave). req/we/addr/wdata are held from request until ack.
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ack
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers EX/MEM into MEM/WB, runs loads/stores over a req/ack
// port with variable latency, stalls upstream meanwhile, and times out with a sticky error.
module mem_stage #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        HALTED,
    input  logic [31:0] EX_MEM_ALUOUT,
    input  logic [31:0] EX_MEM_B,
    input  logic [31:0] EX_MEM_IR,
    input  logic [2:0]  EX_MEM_TYPE,
    input  logic        TAKEN_BRANCH,
    mem_stage_if.master mem,
    output logic        STALL,
    output logic [31:0] MEM_WB_ALUOUT,
    output logic [31:0] MEM_WB_LMD,
    output logic [31:0] MEM_WB_IR,
    output logic [2:0]  MEM_WB_TYPE,
    output logic        MEM_WB_VALID,
    output logic        BUS_ERR
);

    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] TYPE_LOAD  = 3'b010;
    localparam logic [2:0] TYPE_STORE = 3'b011;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]       state_reg,      state_next;
    logic [CNT_W-1:0] cnt_reg,        cnt_next;
    logic             req_reg,        req_next;
    logic             we_reg,         we_next;
    logic [31:0]      addr_reg,       addr_next;
    logic [31:0]      wdata_reg,      wdata_next;
    logic [31:0]      lat_ir_reg,     lat_ir_next;
    logic [2:0]       lat_type_reg,   lat_type_next;
    logic [31:0]      wb_aluout_reg,  wb_aluout_next;
    logic [31:0]      wb_lmd_reg,     wb_lmd_next;
    logic [31:0]      wb_ir_reg,      wb_ir_next;
    logic [2:0]       wb_type_reg,    wb_type_next;
    logic             wb_valid_reg,   wb_valid_next;
    logic             stall_reg,      stall_next;
    logic             bus_err_reg,    bus_err_next;

    logic is_mem_op;
    logic access_done;

    // A store squashed by a taken branch behaves like any non-memory op.
    assign is_mem_op   = (EX_MEM_TYPE == TYPE_LOAD) ||
                         ((EX_MEM_TYPE == TYPE_STORE) && !TAKEN_BRANCH);
    assign access_done = mem.ack || (cnt_reg == CNT_LAST);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        req_next       = req_reg;
        we_next        = we_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        lat_ir_next    = lat_ir_reg;
        lat_type_next  = lat_type_reg;
        wb_aluout_next = wb_aluout_reg;
        wb_lmd_next    = wb_lmd_reg;
        wb_ir_next     = wb_ir_reg;
        wb_type_next   = wb_type_reg;
        wb_valid_next  = 1'b0;
        bus_err_next   = bus_err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (!HALTED) begin
                    if (is_mem_op) begin
                        // The address register doubles as the latched ALU result.
                        lat_ir_next   = EX_MEM_IR;
                        lat_type_next = EX_MEM_TYPE;
                        req_next      = 1'b1;
                        we_next       = (EX_MEM_TYPE == TYPE_STORE);
                        addr_next     = EX_MEM_ALUOUT;
                        wdata_next    = EX_MEM_B;
                        cnt_next      = '0;
                        state_next    = ST_ACCESS;
                    end else begin
                        wb_aluout_next = EX_MEM_ALUOUT;
                        wb_ir_next     = EX_MEM_IR;
                        wb_type_next   = EX_MEM_TYPE;
                        wb_valid_next  = 1'b1;
                    end
                end
            end

            ST_ACCESS: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (access_done) begin
                    req_next       = 1'b0;
                    wb_aluout_next = addr_reg;
                    wb_ir_next     = lat_ir_reg;
                    wb_type_next   = lat_type_reg;
                    wb_valid_next  = 1'b1;
                    cnt_next       = '0;
                    state_next     = ST_IDLE;
                    // An ack arriving on the timeout cycle still delivers real data.
                    if (lat_type_reg == TYPE_LOAD) begin
                        wb_lmd_next = mem.ack ? mem.rdata : ERR_DATA;
                    end
                    if (!mem.ack) begin
                        bus_err_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                req_next   = 1'b0;
            end
        endcase

        stall_next = (state_next == ST_ACCESS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            req_reg       <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            lat_ir_reg    <= '0;
            lat_type_reg  <= '0;
            wb_aluout_reg <= '0;
            wb_lmd_reg    <= '0;
            wb_ir_reg     <= '0;
            wb_type_reg   <= '0;
            wb_valid_reg  <= 1'b0;
            stall_reg     <= 1'b0;
            bus_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            req_reg       <= req_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            lat_ir_reg    <= lat_ir_next;
            lat_type_reg  <= lat_type_next;
            wb_aluout_reg <= wb_aluout_next;
            wb_lmd_reg    <= wb_lmd_next;
            wb_ir_reg     <= wb_ir_next;
            wb_type_reg   <= wb_type_next;
            wb_valid_reg  <= wb_valid_next;
            stall_reg     <= stall_next;
            bus_err_reg   <= bus_err_next;
        end
    end

    assign mem.req       = req_reg;
    assign mem.we        = we_reg;
    assign mem.addr      = addr_reg;
    assign mem.wdata     = wdata_reg;
    assign STALL         = stall_reg;
    assign MEM_WB_ALUOUT = wb_aluout_reg;
    assign MEM_WB_LMD    = wb_lmd_reg;
    assign MEM_WB_IR     = wb_ir_reg;
    assign MEM_WB_TYPE   = wb_type_reg;
    assign MEM_WB_VALID  = wb_valid_reg;
    assign BUS_ERR       = bus_err_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: randomized ALU and memory ops against a
// retirement-level reference model, with a behavioural memory responder.
module tb_mem_stage;

    localparam int          TO  = 16;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halted;
    logic [31:0] ex_aluout;
    logic [31:0] ex_b;
    logic [31:0] ex_ir;
    logic [2:0]  ex_type;
    logic        taken_branch;
    logic        stall;
    logic [31:0] wb_aluout;
    logic [31:0] wb_lmd;
    logic [31:0] wb_ir;
    logic [2:0]  wb_type;
    logic        wb_valid;
    logic        bus_err;

    mem_stage_if mem_bus();

    mem_stage #(
        .TIMEOUT  (TO),
        .ERR_DATA (ERR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .HALTED        (halted),
        .EX_MEM_ALUOUT (ex_aluout),
        .EX_MEM_B      (ex_b),
        .EX_MEM_IR     (ex_ir),
        .EX_MEM_TYPE   (ex_type),
        .TAKEN_BRANCH  (taken_branch),
        .mem           (mem_bus),
        .STALL         (stall),
        .MEM_WB_ALUOUT (wb_aluout),
        .MEM_WB_LMD    (wb_lmd),
        .MEM_WB_IR     (wb_ir),
        .MEM_WB_TYPE   (wb_type),
        .MEM_WB_VALID  (wb_valid),
        .BUS_ERR       (bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural MEM/WB contents after the latest retirement.
    logic [31:0] m_aluout, m_lmd, m_ir;
    logic [2:0]  m_type;
    logic        m_bus_err;

    task automatic model_clear();
        m_aluout = '0; m_lmd = '0; m_ir = '0; m_type = '0; m_bus_err = 1'b0;
    endtask

    task automatic drive_random_ex();
        ex_aluout    = $urandom;
        ex_b         = $urandom;
        ex_ir        = $urandom;
        ex_type      = 3'($urandom_range(0, 7));
        taken_branch = 1'($urandom_range(0, 1));
    endtask

    // Non-memory op (or squashed store): retires at the next edge.
    task automatic do_alu_op(input logic [2:0] typ, input logic tb, input logic [31:0] alu);
        logic [31:0] ir;
        ir = $urandom;
        halted = 1'b0; ex_type = typ; taken_branch = tb; ex_aluout = alu; ex_ir = ir; ex_b = $urandom;
        mem_bus.ack = 1'($urandom_range(0, 1));
        mem_bus.rdata = $urandom;
        @(negedge clk);
        mem_bus.ack = 1'b0;
        m_aluout = alu; m_ir = ir; m_type = typ;
        checks++;
        if ({mem_bus.req, stall, wb_valid} !== 3'b001) begin
            errors++;
            $display("FAIL alu_ctrl: req/stall/valid=%b expected 001", {mem_bus.req, stall, wb_valid});
        end
        checks++;
        if ({wb_aluout, wb_lmd, wb_ir, wb_type, bus_err} !== {m_aluout, m_lmd, m_ir, m_type, m_bus_err}) begin
            errors++;
            $display("FAIL alu_wb: alu=%h lmd=%h ir=%h type=%b err=%b expected alu=%h lmd=%h ir=%h type=%b err=%b",
                     wb_aluout, wb_lmd, wb_ir, wb_type, bus_err, m_aluout, m_lmd, m_ir, m_type, m_bus_err);
        end
        $display("alu op  type=%b tb=%b alu=%h -> valid=%b alu=%h", typ, tb, alu, wb_valid, wb_aluout);
    endtask

    // Memory op with an ack in ACCESS cycle 'delay' (1-based); delay 0 or >TO means no ack.
    task automatic do_mem_op(input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] b,
                             input int delay, input logic [31:0] rd, input logic halt_mid);
        logic [31:0] ir;
        logic        acked;
        int          n_cyc;
        ir = $urandom;
        halted = 1'b0; ex_type = typ; ex_aluout = addr; ex_b = b; ex_ir = ir;
        taken_branch = (typ == 3'b010) ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_bus.ack = 1'b0;
        @(negedge clk);
        acked = (delay >= 1) && (delay <= TO);
        n_cyc = acked ? delay : TO;
        for (int c = 0; c < n_cyc; c++) begin
            checks++;
            if ({mem_bus.req, mem_bus.we, stall, wb_valid} !== {1'b1, (typ == 3'b011), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL access_ctrl cyc %0d: req/we/stall/valid=%b expected %b", c,
                         {mem_bus.req, mem_bus.we, stall, wb_valid}, {1'b1, (typ == 3'b011), 1'b1, 1'b0});
            end
            checks++;
            if ({mem_bus.addr, mem_bus.wdata, bus_err} !== {addr, b, m_bus_err}) begin
                errors++;
                $display("FAIL access_bus cyc %0d: addr=%h wdata=%h err=%b expected addr=%h wdata=%h err=%b",
                         c, mem_bus.addr, mem_bus.wdata, bus_err, addr, b, m_bus_err);
            end
            drive_random_ex();
            halted = halt_mid;
            mem_bus.ack = acked && (c == delay - 1);
            mem_bus.rdata = mem_bus.ack ? rd : $urandom;
            @(negedge clk);
        end
        mem_bus.ack = 1'b0;
        m_aluout = addr; m_ir = ir; m_type = typ;
        if (typ == 3'b010) m_lmd = acked ? rd : ERR;
        if (!acked) m_bus_err = 1'b1;
        checks++;
        if ({mem_bus.req, stall, wb_valid} !== 3'b001) begin
            errors++;
            $display("FAIL retire_ctrl: req/stall/valid=%b expected 001", {mem_bus.req, stall, wb_valid});
        end
        checks++;
        if ({wb_aluout, wb_lmd, wb_ir, wb_type, bus_err} !== {m_aluout, m_lmd, m_ir, m_type, m_bus_err}) begin
            errors++;
            $display("FAIL retire_wb: alu=%h lmd=%h ir=%h type=%b err=%b expected alu=%h lmd=%h ir=%h type=%b err=%b",
                     wb_aluout, wb_lmd, wb_ir, wb_type, bus_err, m_aluout, m_lmd, m_ir, m_type, m_bus_err);
        end
        $display("mem op  type=%b addr=%h delay=%0d -> stall %0d cyc lmd=%h err=%b",
                 typ, addr, delay, n_cyc, wb_lmd, bus_err);
    endtask

    task automatic check_idle_hold(input string name);
        checks++;
        if ({mem_bus.req, stall, wb_valid, wb_aluout, wb_lmd, wb_ir, wb_type, bus_err} !==
            {3'b000, m_aluout, m_lmd, m_ir, m_type, m_bus_err}) begin
            errors++;
            $display("FAIL %s: req/stall/valid=%b alu=%h lmd=%h ir=%h type=%b err=%b expected 000 alu=%h lmd=%h ir=%h type=%b err=%b",
                     name, {mem_bus.req, stall, wb_valid}, wb_aluout, wb_lmd, wb_ir, wb_type, bus_err,
                     m_aluout, m_lmd, m_ir, m_type, m_bus_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; halted = 1'b0; mem_bus.ack = 1'b0; mem_bus.rdata = '0;
        drive_random_ex();
        model_clear();
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_bus.req, mem_bus.we, mem_bus.addr, mem_bus.wdata, stall, wb_valid, bus_err,
             wb_aluout, wb_lmd, wb_ir, wb_type} !== '0) begin
            errors++;
            $display("FAIL reset_state: req=%b stall=%b valid=%b err=%b alu=%h expected all zero",
                     mem_bus.req, stall, wb_valid, bus_err, wb_aluout);
        end
        rst_n = 1'b1;
        $display("reset   -> outputs zero");
    endtask

    task automatic test_alu_ops();
        int k;
        do_alu_op(3'b001, 1'b0, 32'd5);
        do_alu_op(3'b011, 1'b1, 32'h0000_0010);
        for (int i = 0; i < 20; i++) begin
            k = $urandom_range(0, 4);
            case (k)
                0: do_alu_op(3'b000, 1'($urandom_range(0, 1)), $urandom);
                1: do_alu_op(3'b001, 1'($urandom_range(0, 1)), $urandom);
                2: do_alu_op(3'b100, 1'($urandom_range(0, 1)), $urandom);
                3: do_alu_op(3'b101, 1'($urandom_range(0, 1)), $urandom);
                default: do_alu_op(3'b011, 1'b1, $urandom);
            endcase
        end
    endtask

    task automatic test_halted();
        halted = 1'b1; ex_type = 3'b010; ex_aluout = $urandom; ex_ir = $urandom; taken_branch = 1'b0;
        mem_bus.ack = 1'b1; mem_bus.rdata = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_hold("halted_hold");
            $display("halted  cyc %0d -> valid=%b req=%b", i, wb_valid, mem_bus.req);
        end
        mem_bus.ack = 1'b0;
    endtask

    task automatic test_load_store();
        do_mem_op(3'b010, 32'h40, $urandom, 3, 32'h1234, 1'b0);
        do_mem_op(3'b011, 32'h10, 32'hAA, $urandom_range(1, 6), $urandom, 1'b0);
        do_mem_op(3'b010, $urandom, $urandom, 1, $urandom, 1'b0);
        for (int i = 0; i < 12; i++) begin
            do_mem_op($urandom_range(0, 1) ? 3'b010 : 3'b011, $urandom, $urandom,
                      $urandom_range(1, 10), $urandom, 1'b0);
        end
    endtask

    task automatic test_ack_at_timeout();
        do_mem_op(3'b010, $urandom, $urandom, TO, 32'hCAFE_F00D, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_mem_op(3'b010, $urandom, $urandom, 2, $urandom, 1'b0);
        do_mem_op(3'b011, $urandom, $urandom, 1, $urandom, 1'b0);
        do_alu_op(3'b000, 1'b0, $urandom);
        do_mem_op(3'b010, $urandom, $urandom, 4, $urandom, 1'b0);
        do_alu_op(3'b100, 1'b1, $urandom);
    endtask

    task automatic test_halt_during_access();
        do_mem_op(3'b010, $urandom, $urandom, 5, $urandom, 1'b1);
        ex_type = 3'b010; taken_branch = 1'b0;
        @(negedge clk);
        check_idle_hold("halt_after_access");
        halted = 1'b0;
    endtask

    task automatic test_timeout();
        do_mem_op(3'b010, $urandom, $urandom, 0, $urandom, 1'b0);
        do_mem_op(3'b011, $urandom, $urandom, 0, $urandom, 1'b0);
        do_mem_op(3'b010, $urandom, $urandom, 2, $urandom, 1'b0);
        do_alu_op(3'b001, 1'b0, $urandom);
    endtask

    task automatic test_reset_mid_access();
        halted = 1'b0; ex_type = 3'b010; ex_aluout = $urandom; ex_ir = $urandom; taken_branch = 1'b0;
        mem_bus.ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_bus.req, stall} !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset_access: req/stall=%b expected 11", {mem_bus.req, stall});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_bus.req, stall, wb_valid, bus_err, wb_aluout, wb_lmd, wb_ir, wb_type} !== '0) begin
            errors++;
            $display("FAIL reset_mid_access: req=%b stall=%b valid=%b err=%b lmd=%h expected all zero",
                     mem_bus.req, stall, wb_valid, bus_err, wb_lmd);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1; halted = 1'b1;
        @(negedge clk);
        check_idle_hold("after_reset_release");
        $display("reset mid-access -> req=%b stall=%b err=%b", mem_bus.req, stall, bus_err);
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_halted();
        test_load_store();
        test_ack_at_timeout();
        test_back_to_back();
        test_halt_during_access();
        test_timeout();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
